baud_tick_gen: RTL and testbench

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

---
 rtl/baud_tick_gen.sv | 120 ++++++++++++
 tb/tb_baud_tick_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen.sv
// Baud-rate enable generator: a prescaler makes os_tick every div_r+1 cycles and an
// OSR-deep phase counter makes bit_tick. Optional fractional divide: BAUD_TICK_GEN_FRAC_EN.
module baud_tick_gen #(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 249999,
  parameter int OSR         = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [CNT_W-1:0]        div,
  input  logic                    div_load,
  input  logic                    resync,
`ifdef BAUD_TICK_GEN_FRAC_EN
  input  logic [3:0]              div_frac,
`endif
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic [$clog2(OSR)-1:0]  os_phase
);

  localparam int PH_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]  PH_MID  = PH_W'(OSR / 2);

  logic [CNT_W-1:0] div_r_q, div_r_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [PH_W-1:0]  os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             wrap;

`ifdef BAUD_TICK_GEN_FRAC_EN
  logic [3:0] frac_r_q, frac_r_d;
  logic [3:0] acc_q, acc_d;
  logic       stretch_q, stretch_d;
  logic [4:0] acc_sum;

  // A carry from the accumulator lengthens the following period by one cycle.
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_r_q};
  assign wrap    = ({1'b0, pcnt_q} >= ({1'b0, div_r_q} + {{CNT_W{1'b0}}, stretch_q}));
`else
  assign wrap    = (pcnt_q >= div_r_q);
`endif

  always_comb begin
    div_r_d    = div_r_q;
    pcnt_d     = pcnt_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
`ifdef BAUD_TICK_GEN_FRAC_EN
    frac_r_d   = frac_r_q;
    acc_d      = acc_q;
    stretch_d  = stretch_q;
`endif
    if (div_load || resync) begin
      // Load/resync restart the period and suppress any tick at this edge.
      pcnt_d = '0;
      if (div_load) begin
        div_r_d = div;
`ifdef BAUD_TICK_GEN_FRAC_EN
        frac_r_d = div_frac;
`endif
      end
      if (resync) begin
        os_cnt_d = PH_MID;
`ifdef BAUD_TICK_GEN_FRAC_EN
        acc_d     = 4'd0;
        stretch_d = 1'b0;
`endif
      end
    end else if (en) begin
      if (wrap) begin
        pcnt_d     = '0;
        os_tick_d  = 1'b1;
        bit_tick_d = (os_cnt_q == PH_LAST);
        os_cnt_d   = os_cnt_q + 1'b1;
`ifdef BAUD_TICK_GEN_FRAC_EN
        acc_d     = acc_sum[3:0];
        stretch_d = acc_sum[4];
`endif
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_r_q    <= DEF_DIV;
      pcnt_q     <= '0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
`ifdef BAUD_TICK_GEN_FRAC_EN
      frac_r_q   <= 4'd0;
      acc_q      <= 4'd0;
      stretch_q  <= 1'b0;
`endif
    end else begin
      div_r_q    <= div_r_d;
      pcnt_q     <= pcnt_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
`ifdef BAUD_TICK_GEN_FRAC_EN
      frac_r_q   <= frac_r_d;
      acc_q      <= acc_d;
      stretch_q  <= stretch_d;
`endif
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign os_phase = os_cnt_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: a countdown-to-next-tick model checked every cycle, plus
// hand-computed latency/period checks for reset, enable gaps, resync and reload.
module tb_baud_tick_gen;
  localparam int CNT_W = 8;
  localparam int DEF   = 9;
  localparam int OSR   = 16;
  localparam int PH_W  = $clog2(OSR);

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] div;
  logic             div_load;
  logic             resync;
  logic             os_tick;
  logic             bit_tick;
  logic [PH_W-1:0]  os_phase;

  int n_pass  = 0;
  int n_total = 0;

  baud_tick_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF), .OSR(OSR)) dut (
    .clk_in   (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div      (div),
    .div_load (div_load),
    .resync   (resync),
`ifdef BAUD_TICK_GEN_FRAC_EN
    .div_frac (4'd0),
`endif
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .os_phase (os_phase)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model: counts enabled edges remaining until the next oversample tick.
  int m_div, m_rem, m_phase;
  int e_os, e_bit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div = DEF; m_rem = DEF + 1; m_phase = 0; e_os = 0; e_bit = 0;
    end else begin
      e_os = 0; e_bit = 0;
      if (div_load || resync) begin
        if (div_load) m_div = int'(div);
        m_rem = m_div + 1;
        if (resync) m_phase = OSR / 2;
      end else if (en) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          e_os    = 1;
          m_phase = (m_phase + 1) % OSR;
          e_bit   = (m_phase == 0) ? 1 : 0;
          m_rem   = m_div + 1;
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    check("os_tick", int'(os_tick), e_os);
    check("bit_tick", int'(bit_tick), e_bit);
    check("os_phase", int'(os_phase), m_phase);
  end

  // Counts falling edges until the selected pulse is seen (sel=1: bit_tick).
  task automatic wait_sig(input bit sel, input int limit, output int n);
    bit seen;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      seen = sel ? bit_tick : os_tick;
    end while (!seen && n < limit);
    if (!seen) check(sel ? "bit_tick_timeout" : "os_tick_timeout", 0, 1);
  endtask

  task automatic strobe(input logic ld, input logic rs, input int dv);
    @(negedge clk);
    div = CNT_W'(dv); div_load = ld; resync = rs;
    @(negedge clk);
    div_load = 1'b0; resync = 1'b0;
  endtask

  initial begin
    int n, k;
    bit seen;
    rst_n = 1'b0; en = 1'b0; div = '0; div_load = 1'b0; resync = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_os_tick", int'(os_tick), 0);
    check("reset_bit_tick", int'(bit_tick), 0);
    check("reset_os_phase", int'(os_phase), 0);

    // release: first tick 10 cycles, first bit_tick at 160, then every 160
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    wait_sig(1'b0, 50, n);
    check("first_os_tick_latency", n, 10);
    wait_sig(1'b1, 300, k);
    check("first_bit_tick_latency", n + k, 160);
    wait_sig(1'b1, 300, n);
    check("bit_tick_period", n, 160);
    check("phase_at_bit_tick", int'(os_phase), 0);

    // enable dropped for 7 edges mid-period
    wait_sig(1'b0, 20, n);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      seen = os_tick;
      en = !(k >= 3 && k < 10);
    end while (!seen && k < 40);
    en = 1'b1;
    check("en_gap_period", k, 17);

    // resync: phase 8 next cycle, bit_tick 80 cycles after the resync edge
    strobe(1'b0, 1'b1, 0);
    check("resync_phase", int'(os_phase), 8);
    wait_sig(1'b1, 120, n);
    check("resync_bit_latency", n, 80);

    // load div=4 with resync while pcnt=7
    wait_sig(1'b0, 20, n);
    repeat (6) @(negedge clk);
    strobe(1'b1, 1'b1, 4);
    check("load_resync_phase", int'(os_phase), 8);
    wait_sig(1'b0, 20, n);
    check("load_resync_tick_latency", n, 5);

    // div=0: tick every cycle, bit_tick every 16
    strobe(1'b1, 1'b0, 0);
    wait_sig(1'b0, 5, n);
    check("div0_first_tick", n, 1);
    wait_sig(1'b1, 40, n);
    wait_sig(1'b1, 40, n);
    check("div0_bit_period", n, 16);

    // randomized traffic checked by the model
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 9) != 0);
      div      = CNT_W'($urandom_range(0, 12));
      div_load = ($urandom_range(0, 99) == 0);
      resync   = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    div_load = 1'b0; resync = 1'b0; en = 1'b1;

    // reset just before a pending tick: outputs clear at once, divisor back to default
    strobe(1'b1, 1'b0, 5);
    wait_sig(1'b0, 20, n);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_os_tick", int'(os_tick), 0);
    check("async_reset_bit_tick", int'(bit_tick), 0);
    check("async_reset_os_phase", int'(os_phase), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(1'b0, 50, n);
    check("post_reset_tick_latency", n, 10);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
